// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, key-length encodings and GF(2^8) helpers.
package aes_pkg;

  typedef logic [0:31]  word_t;
  typedef logic [0:127] rkey_t;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  function automatic logic [3:0] aes_nk(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] aes_nr(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128/192/256 key expansion, one word per cycle, with indexed
// 128-bit round-key readout from the internal word store.
module aes_key_sched_seq #(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [0:32*MAX_NK-1]    key,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [3:0]              rk_idx,
  output logic [0:127]            rk
);
  import aes_pkg::*;

  localparam int NW = 4 * MAX_NR + 4;
  localparam int IW = $clog2(NW);

  state_e        state, state_nx;
  key_len_e      len_q, len_in;
  logic [IW-1:0] i_q, last_idx, rd_base;
  logic [2:0]    j_q;
  logic [7:0]    rc_q;
  logic          valid_q;
  logic [3:0]    nk, nr, nk_in;
  logic          go, bad, wr, fin, rd_ok;
  word_t         w [NW];
  word_t         prev, far, rot_in, sub_out, t, w_new;

  assign len_in   = key_len_e'(key_len);
  assign nk_in    = aes_nk(len_in);
  assign nk       = aes_nk(len_q);
  assign nr       = aes_nr(len_q);
  assign last_idx = IW'({nr, 2'b00}) + IW'(3);
  assign go       = (state == IDLE) && start && (len_in != KL_BAD);
  assign bad      = (state == IDLE) && start && (len_in == KL_BAD);
  assign busy     = (state == EXPAND);

  // Recurrence operands: w[i-1] feeds the transform, w[i-Nk] is the XOR partner.
  assign prev   = w[i_q - IW'(1)];
  assign far    = w[i_q - IW'(nk)];
  assign rot_in = (j_q == 3'd0) ? {prev[8:31], prev[0:7]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (.a(rot_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    t = prev;
    if (j_q == 3'd0)
      t = sub_out ^ {rc_q, 24'h0};
    else if (nk == 4'd8 && j_q == 3'd4)
      t = sub_out;
  end

  assign w_new = far ^ t;

  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE:   if (go) state_nx = EXPAND;
      EXPAND: begin
        wr = 1'b1;
        if (i_q == last_idx) begin
          state_nx = IDLE;
          fin      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_ok   = valid_q && (rk_idx <= nr);
  assign rd_base = IW'({rk_idx, 2'b00});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= KL_128;
      i_q     <= '0;
      j_q     <= '0;
      rc_q    <= 8'h01;
      valid_q <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rk      <= '0;
    end else begin
      state <= state_nx;
      done  <= fin;
      err   <= bad;
      if (go) begin
        len_q   <= len_in;
        i_q     <= IW'(nk_in);
        j_q     <= '0;
        rc_q    <= 8'h01;
        valid_q <= 1'b0;
      end else if (wr) begin
        i_q <= i_q + IW'(1);
        j_q <= ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rc_q <= xtime(rc_q);
        if (fin) valid_q <= 1'b1;
      end
      rk <= rd_ok ? {w[rd_base], w[rd_base + IW'(1)], w[rd_base + IW'(2)], w[rd_base + IW'(3)]}
                  : '0;
    end
  end

  // NOTE: the word store has no reset; valid_q gates every read, so stale
  // contents are never observable and the array maps to plain storage.
  always_ff @(posedge clk) begin
    if (go) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk_in)) w[k] <= key[32*k +: 32];
    end else if (wr) begin
      w[i_q] <= w_new;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Self-checking bench for aes_key_sched_seq: FIPS-197 vectors, handshake corner
// cases and randomized keys against a GF(2^8)-derived reference schedule.
module tb_aes_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic [0:255] key;
  logic         busy, done, err;
  logic [3:0]   rk_idx;
  logic [0:127] rk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  aes_key_sched_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err), .rk_idx(rk_idx), .rk(rk)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(a));
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_gf(input int n);
    logic [7:0] r = 8'h01;
    for (int e = 1; e < n; e++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic void model_expand(input int nk, input logic [0:255] k);
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
    for (int i = nk; i < 4*nr + 4; i++) begin
      logic [31:0] t = mw[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_gf(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endfunction

  function automatic logic [127:0] model_rk(input int idx);
    return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
  endfunction

  function automatic logic [0:255] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_run(input logic [1:0] kl, input logic [0:255] k);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    key     = rand256();
    key_len = 2'($urandom_range(0, 3));
  endtask

  // Counts cycles since the start edge until done; optionally pokes start mid-run.
  task automatic wait_done(input int cyc0, input int poke_at, output int cyc, output logic dropped);
    int c = cyc0;
    dropped = 1'b0;
    while (!done && c < 200) begin
      if (!busy) dropped = 1'b1;
      if (c == poke_at) begin
        start   = 1'b1;
        key_len = 2'($urandom_range(0, 2));
        key     = rand256();
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    cyc = c;
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    rk_idx = 4'(idx);
    @(posedge clk); #1;
    v = rk;
  endtask

  task automatic check_sched(input string tag, input int nk);
    logic [127:0] v;
    for (int idx = 0; idx <= nk + 6; idx++) begin
      read_rk(idx, v);
      check($sformatf("%s_rk%0d", tag, idx), v, model_rk(idx));
    end
    read_rk(nk + 7, v);
    check({tag, "_past_nr"}, v, '0);
  endtask

  task automatic full_run(input string tag, input logic [1:0] kl, input logic [0:255] k, input int poke_at);
    int          nk = 4 + 2 * int'(kl);
    int          cyc;
    logic        dropped;
    model_expand(nk, k);
    start_run(kl, k);
    wait_done(1, poke_at, cyc, dropped);
    check({tag, "_latency"}, 128'(cyc), 128'(4 * (nk + 6) + 4 - nk + 1));
    check({tag, "_busy_at_done"}, 128'(busy), 128'(0));
    check({tag, "_busy_held"}, 128'(dropped), 128'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 128'(done), 128'(0));
    check_sched(tag, nk);
  endtask

  localparam logic [0:255] K1   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K2   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [127:0] v;
    int           cyc;
    logic         dropped;
    logic         saw_done;

    build_sbox();
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 128'({busy, done, err}), 128'(0));
    check("reset_rk", 128'(rk), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: AES-128 FIPS vector
    full_run("t1", 2'd0, K1, -1);
    read_rk(10, v);
    check("t1_vec_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Test 2: AES-128 vectors
    full_run("t2a", 2'd0, K2, -1);
    read_rk(10, v);
    check("t2a_vec_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    full_run("t2b", 2'd0, '0, -1);
    read_rk(1, v);
    check("t2b_vec_rk1", v, {4{32'h62636363}});
    read_rk(10, v);
    check("t2b_vec_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Test 3: AES-192
    full_run("t3", 2'd1, K192, -1);
    read_rk(12, v);
    check("t3_vec_rk12_low", 128'(v[31:0]), 128'(32'h01002202));
    read_rk(13, v);
    check("t3_rk13_zero", v, '0);

    // Test 4: AES-256
    full_run("t4", 2'd2, K256, -1);
    read_rk(14, v);
    check("t4_vec_rk14_low", 128'(v[31:0]), 128'(32'h706c631e));
    read_rk(15, v);
    check("t4_rk15_zero", v, '0);

    // Test 5a: illegal key length is rejected, schedule stays readable
    start_run(2'd3, rand256());
    check("t5_err_pulse", 128'({err, busy}), 128'(2'b10));
    @(posedge clk); #1;
    check("t5_err_clear", 128'({err, busy}), 128'(2'b00));
    read_rk(14, v);
    check("t5_sched_kept", v, model_rk(14));

    // Test 5b: start pulsed mid-run is ignored
    full_run("t5b", 2'd0, K1, 10);

    // Start in the same cycle as done: new run accepted, valid drops
    model_expand(4, K2);
    start_run(2'd0, K2);
    wait_done(1, -1, cyc, dropped);
    check("sd_first_latency", 128'(cyc), 128'(41));
    model_expand(6, K192);
    rk_idx = 4'd3;
    start_run(2'd1, K192);
    check("sd_busy_done", 128'({busy, done}), 128'(2'b10));
    @(posedge clk); #1;
    check("sd_valid_drop", 128'(rk), '0);
    wait_done(2, -1, cyc, dropped);
    check("sd_second_latency", 128'(cyc), 128'(47));
    check_sched("sd", 6);

    // Test 6: reset mid-run aborts
    start_run(2'd0, K1);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_abort_flags", 128'({busy, done, err}), 128'(0));
    check("t6_abort_rk", 128'(rk), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("t6_no_done", 128'(saw_done), 128'(0));
    read_rk(0, v);
    check("t6_invalid_rk", v, '0);
    full_run("t6r", 2'd0, K1, -1);
    read_rk(10, v);
    check("t6r_vec_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Randomized keys and lengths, with stray start pokes
    for (int r = 0; r < 6; r++) begin
      full_run($sformatf("rnd%0d", r), 2'($urandom_range(0, 2)), rand256(),
               int'($urandom_range(3, 30)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
